// File: rtl/arduino_packet_rx.sv
`default_nettype none
// ============================================================================
// Module  : arduino_packet_rx
// Brief   : Oversampled SPI-slave receiver for fixed-size Arduino IMU packets.
// Revision: 1.0
// ============================================================================
module arduino_packet_rx #(
  parameter int              PACKET_SIZE    = 16,
  parameter logic [7:0]      HEADER_BYTE    = 8'hAA,
  parameter int              TIMEOUT_CYCLES = 100000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ard_cs_n,
  input  logic                         ard_sck,
  input  logic                         ard_mosi,
  output logic                         ard_miso,
  output logic [PACKET_SIZE-1:0][7:0]  packet_buffer,
  output logic                         packet_valid,
  output logic                         initialized,
  output logic                         error,
  output logic [15:0]                  pkt_count
);

  localparam int BCW = $clog2(PACKET_SIZE + 1);
  localparam int BIW = $clog2(PACKET_SIZE);
  localparam int TW  = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_ABORT, S_CHECK} state_t;

  state_t                        r_state, w_state_next;
  logic                          r_cs_meta, r_cs_sync, r_cs_dly;
  logic                          r_sck_meta, r_sck_sync, r_sck_dly;
  logic                          r_mosi_meta, r_mosi_sync;
  logic [6:0]                    r_shift;
  logic [2:0]                    r_bit_cnt;
  logic [BCW-1:0]                r_byte_cnt;
  logic                          r_long;
  logic [TW-1:0]                 r_timer;
  logic [PACKET_SIZE-1:0][7:0]   r_staging;

  logic w_sck_rise, w_cs_fall, w_cs_rise, w_timeout, w_pkt_ok;
  logic [7:0] w_byte;

  assign ard_miso   = 1'b0;
  assign w_sck_rise = r_sck_sync & ~r_sck_dly;
  assign w_cs_fall  = ~r_cs_sync & r_cs_dly;
  assign w_cs_rise  = r_cs_sync & ~r_cs_dly;
  assign w_timeout  = (r_timer == TW'(TIMEOUT_CYCLES - 1));
  assign w_byte     = {r_shift, r_mosi_sync};
  // A 17th byte leaves byte_cnt saturated at PACKET_SIZE, so r_long must veto it.
  assign w_pkt_ok   = (r_byte_cnt == BCW'(PACKET_SIZE)) && (r_bit_cnt == 3'd0) &&
                      (r_staging[0] == HEADER_BYTE) && !r_long;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cs_meta   <= 1'b1;
      r_cs_sync   <= 1'b1;
      r_cs_dly    <= 1'b1;
      r_sck_meta  <= 1'b0;
      r_sck_sync  <= 1'b0;
      r_sck_dly   <= 1'b0;
      r_mosi_meta <= 1'b0;
      r_mosi_sync <= 1'b0;
    end else begin
      r_cs_meta   <= ard_cs_n;
      r_cs_sync   <= r_cs_meta;
      r_cs_dly    <= r_cs_sync;
      r_sck_meta  <= ard_sck;
      r_sck_sync  <= r_sck_meta;
      r_sck_dly   <= r_sck_sync;
      r_mosi_meta <= ard_mosi;
      r_mosi_sync <= r_mosi_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_cs_fall) w_state_next = S_RECV;
      S_RECV: begin
        if (w_cs_rise)                      w_state_next = S_CHECK;
        else if (!w_sck_rise && w_timeout)  w_state_next = S_ABORT;
      end
      S_ABORT: if (w_cs_rise) w_state_next = S_IDLE;
      S_CHECK: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift       <= '0;
      r_bit_cnt     <= '0;
      r_byte_cnt    <= '0;
      r_long        <= 1'b0;
      r_timer       <= '0;
      r_staging     <= '0;
      packet_buffer <= '0;
      packet_valid  <= 1'b0;
      initialized   <= 1'b0;
      error         <= 1'b0;
      pkt_count     <= '0;
    end else begin
      packet_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_cs_fall) begin
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
            r_long     <= 1'b0;
            r_timer    <= '0;
          end
        end
        S_RECV: begin
          if (w_sck_rise) begin
            r_timer   <= '0;
            r_shift   <= w_byte[6:0];
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              if (r_byte_cnt < BCW'(PACKET_SIZE)) begin
                r_staging[r_byte_cnt[BIW-1:0]] <= w_byte;
                r_byte_cnt <= r_byte_cnt + BCW'(1);
              end else begin
                r_long <= 1'b1;
              end
            end
          end else begin
            r_timer <= r_timer + TW'(1);
            if (w_timeout && !w_cs_rise) error <= 1'b1;
          end
        end
        S_CHECK: begin
          if (w_pkt_ok) begin
            packet_buffer <= r_staging;
            packet_valid  <= 1'b1;
            initialized   <= 1'b1;
            error         <= 1'b0;
            pkt_count     <= pkt_count + 16'd1;
          end else begin
            error <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_arduino_packet_rx.sv
`default_nettype none
// ============================================================================
// Module  : tb_arduino_packet_rx
// Brief   : Scoreboard bench for arduino_packet_rx using directed SPI packets.
// Revision: 1.0
// ============================================================================
module tb_arduino_packet_rx;
  localparam int PS = 16;
  localparam int TO = 300;

  typedef logic [PS-1:0][7:0] pkt_t;
  typedef struct packed { pkt_t data; logic [15:0] cnt; } exp_t;

  logic clk = 1'b0, rst_n = 1'b0, cs_n = 1'b1, sck = 1'b0, mosi = 1'b0;
  logic miso, pvalid, init, err;
  logic [15:0] cnt;
  pkt_t pbuf;

  exp_t q[$];
  int checks = 0, failures = 0;
  logic [15:0] exp_cnt = 16'd0;
  pkt_t last_good = '0;

  arduino_packet_rx #(.PACKET_SIZE(PS), .HEADER_BYTE(8'hAA), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ard_cs_n(cs_n), .ard_sck(sck), .ard_mosi(mosi),
    .ard_miso(miso), .packet_buffer(pbuf), .packet_valid(pvalid),
    .initialized(init), .error(err), .pkt_count(cnt));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Mode 0 master: MOSI set while SCK low, sampled on the rising edge; SCK = clk/10.
  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      mosi = b[i];
      #50 sck = 1'b1;
      #50 sck = 1'b0;
    end
  endtask

  task automatic send_pkt(input pkt_t p, input int nbytes, input int extra_bits);
    cs_n = 1'b0;
    #100;
    for (int i = 0; i < nbytes; i++) send_bits((i < PS) ? p[i] : 8'h5A, 8);
    if (extra_bits > 0) send_bits(8'hC3, extra_bits);
    #100 cs_n = 1'b1;
    repeat (12) @(posedge clk);
  endtask

  task automatic send_good(input pkt_t p);
    exp_cnt   = exp_cnt + 16'd1;
    last_good = p;
    q.push_back('{data: p, cnt: exp_cnt});
    send_pkt(p, PS, 0);
  endtask

  task automatic check_bad(input string name);
    check({name, "_error"}, 128'(err), 128'(1'b1));
    check({name, "_buffer_kept"}, 128'(pbuf), 128'(last_good));
    check({name, "_count_kept"}, 128'(cnt), 128'(exp_cnt));
  endtask

  // Monitor: every packet_valid pulse must match the oldest expected packet.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && pvalid) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_packet_valid actual=1 required=0 count=%0d", cnt);
        end else begin
          e = q.pop_front();
          check("commit_buffer", 128'(pbuf), 128'(e.data));
          check("commit_count", 128'(cnt), 128'(e.cnt));
          check("commit_initialized", 128'(init), 128'(1'b1));
          check("commit_error_clear", 128'(err), 128'(1'b0));
        end
        @(negedge clk);
        check("valid_pulse_width", 128'(pvalid), 128'(1'b0));
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    pkt_t p1, p2, p3, bad;
    for (int i = 0; i < PS; i++) begin
      p1[i] = (i == 0) ? 8'hAA : 8'(i * 8'h11);
      p2[i] = (i == 0) ? 8'hAA : 8'(i);
      p3[i] = (i == 0) ? 8'hAA : 8'(8'hF0 - i);
    end
    bad = p2;
    bad[0] = 8'h55;

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("reset_buffer", 128'(pbuf), 128'(0));
    check("reset_count", 128'(cnt), 128'(0));
    check("reset_init", 128'(init), 128'(0));
    check("reset_error", 128'(err), 128'(0));
    check("reset_valid", 128'(pvalid), 128'(0));
    check("miso_zero", 128'(miso), 128'(0));
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    send_good(p1);
    check("p1_byte0", 128'(pbuf[0]), 128'(8'hAA));
    check("p1_byte15", 128'(pbuf[15]), 128'(8'hFF));

    send_pkt(bad, PS, 0);
    check_bad("bad_header");
    send_pkt(p2, PS - 1, 0);
    check_bad("short");
    send_good(p2);
    send_pkt(p3, PS + 1, 0);
    check_bad("long");
    send_pkt(p3, PS, 4);
    check_bad("partial_byte");
    send_good(p3);
    send_good(p1);

    // Stall SCK mid-packet: error only after the timeout window.
    cs_n = 1'b0;
    #100;
    send_bits(8'hAA, 8);
    send_bits(8'h12, 4);
    repeat (100) @(posedge clk);
    @(negedge clk);
    check("before_timeout_error", 128'(err), 128'(1'b0));
    repeat (TO) @(posedge clk);
    @(negedge clk);
    check("timeout_error", 128'(err), 128'(1'b1));
    cs_n = 1'b1;
    repeat (12) @(posedge clk);
    check_bad("after_abort");

    // Async reset in the middle of a packet.
    cs_n = 1'b0;
    #100;
    for (int i = 0; i < 8; i++) send_bits(p2[i], 8);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_buffer", 128'(pbuf), 128'(0));
    check("midrst_count", 128'(cnt), 128'(0));
    check("midrst_init", 128'(init), 128'(0));
    check("midrst_error", 128'(err), 128'(0));
    cs_n = 1'b1;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b1;
    exp_cnt   = 16'd0;
    last_good = '0;
    repeat (4) @(posedge clk);
    send_good(p2);
    send_good(p3);

    repeat (10) @(posedge clk);
    check("scoreboard_drained", 128'(q.size()), 128'(0));
    check("final_count", 128'(cnt), 128'(16'd2));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
